// File: rtl/kim_pipe_pkg.sv
// Shared types and constants for the kim pipeline forwarding/hazard logic.
// The tag entry mirrors one pipeline register's destination write.
package kim_pipe_pkg;

    localparam int MIPS_REGISTER_ADDR_WIDTH = 5;
    localparam int FWD_SEL_REGFILE          = 0;

    // Operand-B immediate select code: all ones at the given select width.
    function automatic int fwd_imm(input int sel_w);
        return (1 << sel_w) - 1;
    endfunction

    typedef struct packed {
        logic                                valid;
        logic [MIPS_REGISTER_ADDR_WIDTH-1:0] dst;
        logic                                is_load;
    } tag_t;

endpackage

// File: rtl/kim_fwd_match.sv
// Youngest-match search of one ID source register against the forwardable
// destination tags (index 0 = EX, the youngest).
module kim_fwd_match
    import kim_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = 2
) (
    input  tag_t [DEPTH-1:0]                    tags,
    input  logic                                src_used,
    input  logic [MIPS_REGISTER_ADDR_WIDTH-1:0] src,
    output logic                                hit,
    output logic [IDX_W-1:0]                    idx,
    output logic                                is_load
);

    always_comb begin
        // NOTE: every output gets a default before the search loop so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        // Scan oldest to youngest so the lowest matching index is written last.
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (src_used && tags[j].valid && (tags[j].dst == src)) begin
                hit     = 1'b1;
                idx     = IDX_W'(j);
                is_load = tags[j].is_load;
            end
        end
    end

endmodule

// File: rtl/kim_hazard_forward_unit.sv
// Forwarding select and load-use hazard unit: tracks destination tags of
// in-flight instructions and registers EX-stage operand selects from ID.
module kim_hazard_forward_unit
    import kim_pipe_pkg::*;
#(
    parameter  int ADDR_W         = MIPS_REGISTER_ADDR_WIDTH,
    parameter  int NUM_FWD_STAGES = 2,
    parameter  int LOAD_STAGE     = 2,
    parameter  int CNT_W          = 32,
    localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_alusrc,
    input  logic [ADDR_W-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_flush,
    output logic              stall,
    output logic              bubble,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [SEL_W-1:0]  fwd_c,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int                D           = NUM_FWD_STAGES;
    localparam logic [SEL_W-1:0]  SEL_REGFILE = SEL_W'(FWD_SEL_REGFILE);
    localparam logic [SEL_W-1:0]  SEL_IMM     = SEL_W'(fwd_imm(SEL_W));
    localparam logic [SEL_W-1:0]  SEL_LOAD    = SEL_W'(LOAD_STAGE);

    // Entries 0..D-1 only: the entry leaving stage D is covered by regfile
    // write-through and never influences a select, so it is not stored.
    tag_t [D-1:0]     tag_q, tag_d;
    logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0] fwd_b_q, fwd_b_d;
    logic [SEL_W-1:0] fwd_c_q, fwd_c_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic             hit_rs, hit_rt;
    logic             load_rs, load_rt;
    logic [SEL_W-1:0] idx_rs, idx_rt;
    logic [SEL_W-1:0] sel_rs, sel_rt;
    logic             load_use;
    logic             accept;
    tag_t             id_tag;

    kim_fwd_match #(.DEPTH(D), .IDX_W(SEL_W)) u_match_rs (
        .tags     (tag_q),
        .src_used (id_uses_rs),
        .src      (id_rs),
        .hit      (hit_rs),
        .idx      (idx_rs),
        .is_load  (load_rs)
    );

    kim_fwd_match #(.DEPTH(D), .IDX_W(SEL_W)) u_match_rt (
        .tags     (tag_q),
        .src_used (id_uses_rt),
        .src      (id_rt),
        .hit      (hit_rt),
        .idx      (idx_rt),
        .is_load  (load_rt)
    );

    always_comb begin
        sel_rs = hit_rs ? idx_rs + SEL_W'(1) : SEL_REGFILE;
        sel_rt = hit_rt ? idx_rt + SEL_W'(1) : SEL_REGFILE;

        // A load in stage k can feed EX only once k reaches LOAD_STAGE.
        load_use = (hit_rs && load_rs && (sel_rs < SEL_LOAD))
                || (hit_rt && load_rt && (sel_rt < SEL_LOAD));
        stall    = id_valid && !ex_flush && load_use;
        bubble   = stall || ex_flush;
        accept   = id_valid && !stall && !ex_flush;

        id_tag.valid   = id_reg_write && (id_dst != '0);
        id_tag.dst     = id_dst;
        id_tag.is_load = id_mem_read;

        tag_d[0] = accept ? id_tag : '0;
        for (int k = 1; k < D; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        if (bubble) begin
            fwd_a_d = SEL_REGFILE;
            fwd_b_d = SEL_REGFILE;
            fwd_c_d = SEL_REGFILE;
        end else begin
            fwd_a_d = sel_rs;
            fwd_b_d = id_alusrc ? SEL_IMM : sel_rt;
            fwd_c_d = sel_rt;
        end

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            // NOTE: the tag array is reset, unlike a data RAM, because stale
            // valid bits would create false forwards and phantom stalls.
            tag_q         <= '0;
            fwd_a_q       <= '0;
            fwd_b_q       <= '0;
            fwd_c_q       <= '0;
            stall_count_q <= '0;
        end else begin
            tag_q         <= tag_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            fwd_c_q       <= fwd_c_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign fwd_c       = fwd_c_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_kim_hazard_forward_unit.sv
// Directed bench: a D=2/LOAD_STAGE=2 unit and a D=3/LOAD_STAGE=3 unit with a
// 2-bit stall counter share one ID stimulus stream.
module tb_kim_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs, id_uses_rt, id_alusrc;
    logic       id_reg_write, id_mem_read, ex_flush;
    logic [4:0] id_rs, id_rt, id_dst;

    logic        stall2, bubble2;
    logic [1:0]  fwd_a2, fwd_b2, fwd_c2;
    logic [31:0] cnt2;
    logic        stall3, bubble3;
    logic [2:0]  fwd_a3, fwd_b3, fwd_c3;
    logic [1:0]  cnt3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    kim_hazard_forward_unit #(.NUM_FWD_STAGES(2), .LOAD_STAGE(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_alusrc(id_alusrc),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_flush(ex_flush), .stall(stall2), .bubble(bubble2), .fwd_a(fwd_a2),
        .fwd_b(fwd_b2), .fwd_c(fwd_c2), .stall_count(cnt2)
    );

    kim_hazard_forward_unit #(.NUM_FWD_STAGES(3), .LOAD_STAGE(3), .CNT_W(2)) dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_alusrc(id_alusrc),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_flush(ex_flush), .stall(stall3), .bubble(bubble3), .fwd_a(fwd_a3),
        .fwd_b(fwd_b3), .fwd_c(fwd_c3), .stall_count(cnt3)
    );

    // Present one instruction in ID; ex_flush is cleared unless set afterwards.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic alusrc,
                         input logic [4:0] dst, input logic rw, input logic mr);
        id_valid = v;    id_rs = rs;   id_rt = rt;
        id_uses_rs = urs; id_uses_rt = urt; id_alusrc = alusrc;
        id_dst = dst;    id_reg_write = rw; id_mem_read = mr;
        ex_flush = 1'b0;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (fwd_a2 !== 2'd0 || fwd_b2 !== 2'd0 || fwd_c2 !== 2'd0) begin
            miscompares++; $display("FAIL reset_fwd got %0d/%0d/%0d want 0/0/0", fwd_a2, fwd_b2, fwd_c2); end
        vectors++; if (cnt2 !== 32'd0 || cnt3 !== 2'd0) begin
            miscompares++; $display("FAIL reset_count got %0d/%0d want 0/0", cnt2, cnt3); end
        vectors++; if (stall2 !== 1'b0 || bubble2 !== 1'b0) begin
            miscompares++; $display("FAIL reset_stall_bubble got %b%b want 00", stall2, bubble2); end
        ex_flush = 1'b1; #1;
        vectors++; if (stall2 !== 1'b0 || bubble2 !== 1'b1) begin
            miscompares++; $display("FAIL reset_flush_bubble got %b%b want 01", stall2, bubble2); end
        ex_flush = 1'b0;
    endtask

    // add $3,$1,$2 ; sub $4,$3,$5
    task automatic test_ex_forward();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0); tick();
        drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        vectors++; if (stall2 !== 1'b0) begin
            miscompares++; $display("FAIL ex_fwd_stall got %b want 0", stall2); end
        tick(); nop();
        vectors++; if (fwd_a2 !== 2'd1) begin
            miscompares++; $display("FAIL ex_fwd_a got %0d want 1", fwd_a2); end
        vectors++; if (fwd_b2 !== 2'd0) begin
            miscompares++; $display("FAIL ex_fwd_b got %0d want 0", fwd_b2); end
    endtask

    // add $3 ; nop ; or $6,$3,$3  then the same with an immediate operand B
    task automatic test_mem_forward();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0); tick();
            nop(); tick();
            drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, pass[0], 5'd6, 1'b1, 1'b0); tick();
            nop();
            vectors++; if (fwd_a2 !== 2'd2) begin
                miscompares++; $display("FAIL mem_fwd_a pass %0d got %0d want 2", pass, fwd_a2); end
            vectors++; if (fwd_b2 !== (pass == 1 ? 2'd3 : 2'd2)) begin
                miscompares++; $display("FAIL mem_fwd_b pass %0d got %0d want %0d", pass, fwd_b2, (pass == 1 ? 3 : 2)); end
            vectors++; if (fwd_c2 !== 2'd2) begin
                miscompares++; $display("FAIL mem_fwd_c pass %0d got %0d want 2", pass, fwd_c2); end
        end
    endtask

    // lw $3 ; add $4,$3,$1 with LOAD_STAGE=2
    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1); tick();
        drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        vectors++; if (stall2 !== 1'b1 || bubble2 !== 1'b1) begin
            miscompares++; $display("FAIL load_use_stall got %b%b want 11", stall2, bubble2); end
        tick();
        vectors++; if (stall2 !== 1'b0 || bubble2 !== 1'b0) begin
            miscompares++; $display("FAIL load_use_release got %b%b want 00", stall2, bubble2); end
        vectors++; if (fwd_a2 !== 2'd0) begin
            miscompares++; $display("FAIL load_use_bubble_fwd_a got %0d want 0", fwd_a2); end
        tick(); nop();
        vectors++; if (fwd_a2 !== 2'd2) begin
            miscompares++; $display("FAIL load_use_fwd_a got %0d want 2", fwd_a2); end
        vectors++; if (cnt2 !== 32'd1) begin
            miscompares++; $display("FAIL load_use_count got %0d want 1", cnt2); end
    endtask

    // lw $7 ; sw $7,0($1) on the D=3, LOAD_STAGE=3 unit
    task automatic test_store_two_stalls();
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1); tick();
            drive(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
            vectors++; if (stall3 !== 1'b1) begin
                miscompares++; $display("FAIL sw_stall1 rep %0d got %b want 1", rep, stall3); end
            tick();
            vectors++; if (stall3 !== 1'b1) begin
                miscompares++; $display("FAIL sw_stall2 rep %0d got %b want 1", rep, stall3); end
            vectors++; if (cnt3 !== (rep == 0 ? 2'd1 : 2'd3)) begin
                miscompares++; $display("FAIL sw_count_mid rep %0d got %0d want %0d", rep, cnt3, (rep == 0 ? 1 : 3)); end
            tick();
            vectors++; if (stall3 !== 1'b0) begin
                miscompares++; $display("FAIL sw_release rep %0d got %b want 0", rep, stall3); end
            tick();
            vectors++; if (fwd_c3 !== 3'd3 || fwd_b3 !== 3'd7 || fwd_a3 !== 3'd0) begin
                miscompares++; $display("FAIL sw_fwd rep %0d got c=%0d b=%0d a=%0d want c=3 b=7 a=0", rep, fwd_c3, fwd_b3, fwd_a3); end
            vectors++; if (cnt3 !== (rep == 0 ? 2'd2 : 2'd3)) begin
                miscompares++; $display("FAIL sw_count rep %0d got %0d want %0d", rep, cnt3, (rep == 0 ? 2 : 3)); end
        end
    endtask

    // $zero never forwards; youngest of two writers of $3 wins
    task automatic test_zero_and_youngest();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); tick();
        vectors++; if (fwd_a2 !== 2'd0 || fwd_b2 !== 2'd0) begin
            miscompares++; $display("FAIL zero_fwd got a=%0d b=%0d want 0/0", fwd_a2, fwd_b2); end
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0); tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0); tick();
        drive(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0); tick();
        nop();
        vectors++; if (fwd_a2 !== 2'd1) begin
            miscompares++; $display("FAIL youngest_fwd_a got %0d want 1", fwd_a2); end
    endtask

    // flush beats stall; reset during a stall clears everything
    task automatic test_flush_and_reset();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1); tick();
        drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        ex_flush = 1'b1; #1;
        vectors++; if (stall2 !== 1'b0 || bubble2 !== 1'b1) begin
            miscompares++; $display("FAIL flush_stall got %b%b want 01", stall2, bubble2); end
        tick();
        ex_flush = 1'b0; #1;
        vectors++; if (cnt2 !== 32'd0 || fwd_a2 !== 2'd0) begin
            miscompares++; $display("FAIL flush_count got cnt=%0d a=%0d want 0/0", cnt2, fwd_a2); end
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1); tick();
        drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        vectors++; if (stall2 !== 1'b1) begin
            miscompares++; $display("FAIL mid_reset_pre got %b want 1", stall2); end
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        vectors++; if (stall2 !== 1'b0 || cnt2 !== 32'd0 || fwd_a2 !== 2'd0) begin
            miscompares++; $display("FAIL mid_reset got stall=%b cnt=%0d a=%0d want 0/0/0", stall2, cnt2, fwd_a2); end
    endtask

    initial begin
        reset = 1'b1;
        nop();
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_store_two_stalls();
        test_zero_and_youngest();
        test_flush_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
